// File: rtl/fir_hist_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_hist_axi_bridge_if
// Purpose  : AXI4-Lite signal bundle between the PS interconnect (master)
//            and fir_hist_axi_bridge (slave). There is no clock or reset in
//            the bundle; both stay plain ports of the bridge.
// Signals  : write address s_aw*, write data s_w*, write response s_b*,
//            read address s_ar*, read data s_r*.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_hist_axi_bridge_if;
  logic [7:0]  s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [7:0]  s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/fir_hist_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : fir_hist_axi_bridge
// Purpose  : AXI4-Lite slave that turns coefficient writes and histogram-bin
//            reads into level strobes toward the pixel domain and waits for
//            the matching ack toggle (synchronised here), answering OKAY, or
//            SLVERR on timeout or an unmapped address.
// Ports    : clk, rst        - AXI clock, async active-high reset
//            axi (slave)     - AXI4-Lite channels
//            fir_addr_o      - latched write address
//            fir_coeff_o     - latched write data
//            wr_strobe_o     - write request level, wr_ack_i its ack toggle
//            rd_strobe_o     - read request level, rd_ack_i its ack toggle
//            hist_bin_i      - histogram bin, valid once rd_ack_i toggles
// Map      : W 0x00-0x17 coefficient, R 0x40 next hist bin, R 0x44 status
//            {14'b0, wr_strobe, rd_strobe, timeout_count[15:0]}
// Revision : 1.0 - initial release
// ============================================================================
module fir_hist_axi_bridge #(
  parameter int TIMEOUT_CYCLES    = 65535,
  parameter int STROBE_LOW_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  fir_hist_axi_bridge_if.slave        axi,
  output logic [7:0]                  fir_addr_o,
  output logic [31:0]                 fir_coeff_o,
  output logic                        wr_strobe_o,
  input  logic                        wr_ack_i,
  output logic                        rd_strobe_o,
  input  logic                        rd_ack_i,
  input  logic [31:0]                 hist_bin_i
);
  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] COOL_LAST    = 16'(STROBE_LOW_CYCLES - 1);
  localparam logic [7:0]  FIR_LAST     = 8'h17;
  localparam logic [7:0]  HIST_ADDR    = 8'h40;
  localparam logic [7:0]  STATUS_ADDR  = 8'h44;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_REQ   = 3'd1,
    RD_REQ   = 3'd2,
    B_RESP   = 3'd3,
    R_RESP   = 3'd4,
    COOLDOWN = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [2:0]  wr_sync, rd_sync;            // [0]=q1, [1]=q2, [2]=q3
  logic        wr_evt, rd_evt;
  logic [15:0] cnt, cnt_n;                  // REQ timeout / COOLDOWN length
  logic [15:0] to_count, to_count_n, to_inc;
  logic        wr_strobe_n, rd_strobe_n;
  logic [7:0]  fir_addr_n;
  logic [31:0] fir_coeff_n;
  logic        bvalid, bvalid_n, rvalid, rvalid_n;
  logic [1:0]  bresp, bresp_n, rresp, rresp_n;
  logic [31:0] rdata, rdata_n;
  logic        strobed, strobed_n;          // response belongs to a strobe txn
  logic        wr_accept, ar_accept;

  // Ack toggles: an event is any change seen between q2 and q3. Events are
  // only consumed in the matching REQ state; elsewhere they simply pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sync <= 3'b000;
      rd_sync <= 3'b000;
    end else begin
      wr_sync <= {wr_sync[1:0], wr_ack_i};
      rd_sync <= {rd_sync[1:0], rd_ack_i};
    end
  end

  assign wr_evt = wr_sync[1] ^ wr_sync[2];
  assign rd_evt = rd_sync[1] ^ rd_sync[2];
  assign to_inc = (to_count == 16'hFFFF) ? to_count : to_count + 16'd1;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    to_count_n  = to_count;
    wr_strobe_n = wr_strobe_o;
    rd_strobe_n = rd_strobe_o;
    fir_addr_n  = fir_addr_o;
    fir_coeff_n = fir_coeff_o;
    bvalid_n    = bvalid;
    bresp_n     = bresp;
    rvalid_n    = rvalid;
    rresp_n     = rresp;
    rdata_n     = rdata;
    strobed_n   = strobed;
    wr_accept   = 1'b0;
    ar_accept   = 1'b0;
    case (state)
      IDLE: begin
        // A write needs both address and data; it wins over a pending read.
        if (axi.s_awvalid && axi.s_wvalid) begin
          wr_accept   = 1'b1;
          fir_addr_n  = axi.s_awaddr;
          fir_coeff_n = axi.s_wdata;
          cnt_n       = 16'd0;
          if (axi.s_awaddr <= FIR_LAST) begin
            state_n     = WR_REQ;
            wr_strobe_n = 1'b1;
          end else begin
            state_n   = B_RESP;
            bvalid_n  = 1'b1;
            bresp_n   = RESP_SLVERR;
            strobed_n = 1'b0;
          end
        end else if (axi.s_arvalid) begin
          ar_accept = 1'b1;
          cnt_n     = 16'd0;
          if (axi.s_araddr == HIST_ADDR) begin
            state_n     = RD_REQ;
            rd_strobe_n = 1'b1;
          end else begin
            state_n   = R_RESP;
            rvalid_n  = 1'b1;
            strobed_n = 1'b0;
            if (axi.s_araddr == STATUS_ADDR) begin
              rresp_n = RESP_OKAY;
              rdata_n = {14'd0, wr_strobe_o, rd_strobe_o, to_count};
            end else begin
              rresp_n = RESP_SLVERR;
              rdata_n = 32'd0;
            end
          end
        end
      end
      WR_REQ: begin
        if (wr_evt) begin
          state_n     = B_RESP;
          wr_strobe_n = 1'b0;
          bvalid_n    = 1'b1;
          bresp_n     = RESP_OKAY;
          strobed_n   = 1'b1;
        end else if (cnt == TIMEOUT_LAST) begin
          state_n     = B_RESP;
          wr_strobe_n = 1'b0;
          bvalid_n    = 1'b1;
          bresp_n     = RESP_SLVERR;
          strobed_n   = 1'b1;
          to_count_n  = to_inc;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      RD_REQ: begin
        if (rd_evt) begin
          state_n     = R_RESP;
          rd_strobe_n = 1'b0;
          rvalid_n    = 1'b1;
          rresp_n     = RESP_OKAY;
          rdata_n     = hist_bin_i;
          strobed_n   = 1'b1;
        end else if (cnt == TIMEOUT_LAST) begin
          state_n     = R_RESP;
          rd_strobe_n = 1'b0;
          rvalid_n    = 1'b1;
          rresp_n     = RESP_SLVERR;
          rdata_n     = 32'd0;
          strobed_n   = 1'b1;
          to_count_n  = to_inc;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      B_RESP: begin
        if (axi.s_bready) begin
          bvalid_n = 1'b0;
          cnt_n    = 16'd0;
          state_n  = strobed ? COOLDOWN : IDLE;
        end
      end
      R_RESP: begin
        if (axi.s_rready) begin
          rvalid_n = 1'b0;
          cnt_n    = 16'd0;
          state_n  = strobed ? COOLDOWN : IDLE;
        end
      end
      COOLDOWN: begin
        // Guarantees the far end sees a low strobe before the next rise.
        if (cnt == COOL_LAST) state_n = IDLE;
        else                  cnt_n   = cnt + 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      to_count    <= 16'd0;
      wr_strobe_o <= 1'b0;
      rd_strobe_o <= 1'b0;
      fir_addr_o  <= 8'd0;
      fir_coeff_o <= 32'd0;
      bvalid      <= 1'b0;
      bresp       <= RESP_OKAY;
      rvalid      <= 1'b0;
      rresp       <= RESP_OKAY;
      rdata       <= 32'd0;
      strobed     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      to_count    <= to_count_n;
      wr_strobe_o <= wr_strobe_n;
      rd_strobe_o <= rd_strobe_n;
      fir_addr_o  <= fir_addr_n;
      fir_coeff_o <= fir_coeff_n;
      bvalid      <= bvalid_n;
      bresp       <= bresp_n;
      rvalid      <= rvalid_n;
      rresp       <= rresp_n;
      rdata       <= rdata_n;
      strobed     <= strobed_n;
    end
  end

  assign axi.s_awready = wr_accept;
  assign axi.s_wready  = wr_accept;
  assign axi.s_arready = ar_accept;
  assign axi.s_bvalid  = bvalid;
  assign axi.s_bresp   = bresp;
  assign axi.s_rvalid  = rvalid;
  assign axi.s_rresp   = rresp;
  assign axi.s_rdata   = rdata;
endmodule
`default_nettype wire

// File: tb/tb_fir_hist_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_hist_axi_bridge
// Purpose  : Self-checking bench for fir_hist_axi_bridge (TIMEOUT_CYCLES=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_hist_axi_bridge;
  localparam int         T      = 16;
  localparam int         SLC    = 4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  fir_addr_o;
  logic [31:0] fir_coeff_o;
  logic        wr_strobe_o, rd_strobe_o;
  logic        wr_ack_i = 1'b0;
  logic        rd_ack_i = 1'b0;
  logic [31:0] hist_bin_i = 32'd0;

  fir_hist_axi_bridge_if bus ();

  fir_hist_axi_bridge #(.TIMEOUT_CYCLES(T), .STROBE_LOW_CYCLES(SLC)) dut (
    .clk(clk), .rst(rst), .axi(bus),
    .fir_addr_o(fir_addr_o), .fir_coeff_o(fir_coeff_o),
    .wr_strobe_o(wr_strobe_o), .wr_ack_i(wr_ack_i),
    .rd_strobe_o(rd_strobe_o), .rd_ack_i(rd_ack_i),
    .hist_bin_i(hist_bin_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_fall = -1000;
  logic [15:0] m_to = 16'd0;   // model: number of timeouts since reset

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] hist;
    int          ack_d;     // cycles after strobe rise to toggle ack, -1 none
    logic [1:0]  e_resp;
    logic [31:0] e_rd;
    int          e_lat;     // from strobe rise, or from handshake if no strobe
    bit          e_strobe;
  } vec_t;

  localparam int NV = 13;
  vec_t vec [NV];

  task automatic check(input string tag, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", tag, idx, act, exp);
    end
  endtask

  // Reference model: outcome of one transaction from the address map and the
  // ack timing rules (ack event 2 cycles after toggle, response 1 later).
  task automatic model_txn(input bit is_wr, input logic [7:0] addr, input int d, input logic [31:0] hist,
                           output logic [1:0] resp, output logic [31:0] rd, output int lat, output bit strobe);
    strobe = is_wr ? (addr < 8'h18) : (addr == 8'h40);
    if (strobe) begin
      if (d >= 1 && d + 3 <= T) begin
        resp = OKAY; rd = is_wr ? 32'd0 : hist; lat = d + 3;
      end else begin
        resp = SLVERR; rd = 32'd0; lat = T;
        if (m_to != 16'hFFFF) m_to = m_to + 16'd1;
      end
    end else begin
      lat = 1;
      if (!is_wr && addr == 8'h44) begin resp = OKAY;   rd = {16'd0, m_to}; end
      else                         begin resp = SLVERR; rd = 32'd0;         end
    end
  endtask

  task automatic run_txn(input bit is_wr, input logic [7:0] addr, input logic [31:0] data,
                         input logic [31:0] hist, input int d,
                         output bit done, output logic [1:0] resp, output logic [31:0] rd,
                         output int lat, output bit seen, output bit stable,
                         output logic [7:0] a0, output logic [31:0] c0);
    int rise, hs;
    bit hs_now, s, toggled;
    rise = -1; hs = -1; done = 0; seen = 0; stable = 1; toggled = 0;
    resp = 2'b11; rd = 32'd0; lat = -1; a0 = 8'd0; c0 = 32'd0;
    @(posedge clk); #1;
    hist_bin_i = hist;
    if (is_wr) begin
      bus.s_awaddr = addr; bus.s_wdata = data; bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    end else begin
      bus.s_araddr = addr; bus.s_arvalid = 1'b1;
    end
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      hs_now = is_wr ? (bus.s_awready && bus.s_wready) : bus.s_arready;
      if (hs_now && hs < 0) hs = cyc;
      s = is_wr ? wr_strobe_o : rd_strobe_o;
      if (s) begin
        seen = 1;
        if (rise < 0) begin
          rise = cyc; a0 = fir_addr_o; c0 = fir_coeff_o;
          n_cmp++;
          if (rise - last_fall < SLC) begin
            n_bad++;
            $display("FAIL strobe_low_gap: got %0d low cycles, need >= %0d", rise - last_fall, SLC);
          end
        end else if (fir_addr_o !== a0 || fir_coeff_o !== c0) begin
          stable = 0;
        end
      end
      if (is_wr ? bus.s_bvalid : bus.s_rvalid) begin
        done = 1;
        resp = is_wr ? bus.s_bresp : bus.s_rresp;
        rd   = bus.s_rdata;
        lat  = seen ? cyc - rise : cyc - hs;
        if (seen) last_fall = cyc;
      end
      @(posedge clk); #1;
      if (hs_now) begin
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
      end
      if (rise >= 0 && !toggled && d >= 1 && cyc == rise + d) begin
        toggled = 1;
        if (is_wr) wr_ack_i = ~wr_ack_i;
        else       rd_ack_i = ~rd_ack_i;
      end
    end
  endtask

  task automatic apply(input string tag, input int idx, input bit is_wr, input logic [7:0] addr,
                       input logic [31:0] data, input logic [31:0] hist, input int d,
                       input logic [1:0] e_resp, input logic [31:0] e_rd, input int e_lat, input bit e_strobe);
    bit done, seen, stable;
    logic [1:0] resp; logic [31:0] rd; int lat; logic [7:0] a0; logic [31:0] c0;
    run_txn(is_wr, addr, data, hist, d, done, resp, rd, lat, seen, stable, a0, c0);
    check({tag, "_done"}, idx, 32'(done), 32'd1);
    check({tag, "_resp"}, idx, 32'(resp), 32'(e_resp));
    if (!is_wr) check({tag, "_rdata"}, idx, rd, e_rd);
    check({tag, "_latency"}, idx, 32'(lat), 32'(e_lat));
    check({tag, "_strobe"}, idx, 32'(seen), 32'(e_strobe));
    if (is_wr && e_strobe) begin
      check({tag, "_fir_addr"}, idx, 32'(a0), 32'(addr));
      check({tag, "_fir_coeff"}, idx, c0, data);
      check({tag, "_held"}, idx, 32'(stable), 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  mr;
    logic [31:0] md, rdv;
    int          ml, wr_hs, ar_hs, bcyc, rcyc, rise, d;
    bit          ms, hsw, hsr, ar_at_wr, got;
    logic [1:0]  br, rr;
    logic [7:0]  a;
    int          kind;

    vec[0]  = '{1'b1, 8'h04, 32'h0000_0123, 32'h0,         10, OKAY,   32'h0,         13, 1'b1};
    vec[1]  = '{1'b0, 8'h40, 32'h0,         32'hDEAD_BEEF,  5, OKAY,   32'hDEAD_BEEF,  8, 1'b1};
    vec[2]  = '{1'b0, 8'h40, 32'h0,         32'h1234_5678,  3, OKAY,   32'h1234_5678,  6, 1'b1};
    vec[3]  = '{1'b1, 8'h14, 32'h0000_CAFE, 32'h0,         12, OKAY,   32'h0,         15, 1'b1};
    vec[4]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0,         -1, SLVERR, 32'h0,         16, 1'b1};
    vec[5]  = '{1'b0, 8'h44, 32'h0,         32'h0,         -1, OKAY,   32'h0000_0001,  1, 1'b0};
    vec[6]  = '{1'b1, 8'h30, 32'h0000_0777, 32'h0,         -1, SLVERR, 32'h0,          1, 1'b0};
    vec[7]  = '{1'b0, 8'h80, 32'h0,         32'h0,         -1, SLVERR, 32'h0,          1, 1'b0};
    vec[8]  = '{1'b0, 8'h40, 32'h0,         32'hA5A5_A5A5, 14, SLVERR, 32'h0,         16, 1'b1};
    vec[9]  = '{1'b0, 8'h44, 32'h0,         32'h0,         -1, OKAY,   32'h0000_0002,  1, 1'b0};
    vec[10] = '{1'b1, 8'h18, 32'h0000_0001, 32'h0,         -1, SLVERR, 32'h0,          1, 1'b0};
    vec[11] = '{1'b1, 8'h17, 32'h0BAD_F00D, 32'h0,          2, OKAY,   32'h0,          5, 1'b1};
    vec[12] = '{1'b1, 8'h00, 32'h8000_0001, 32'h0,          1, OKAY,   32'h0,          4, 1'b1};

    bus.s_awaddr = 8'd0; bus.s_awvalid = 1'b0; bus.s_wdata = 32'd0; bus.s_wvalid = 1'b0;
    bus.s_araddr = 8'd0; bus.s_arvalid = 1'b0; bus.s_bready = 1'b1; bus.s_rready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 0, 32'(bus.s_awready), 0);
    check("rst_wready",  0, 32'(bus.s_wready),  0);
    check("rst_arready", 0, 32'(bus.s_arready), 0);
    check("rst_bvalid",  0, 32'(bus.s_bvalid),  0);
    check("rst_rvalid",  0, 32'(bus.s_rvalid),  0);
    check("rst_bresp",   0, 32'(bus.s_bresp),   0);
    check("rst_rresp",   0, 32'(bus.s_rresp),   0);
    check("rst_rdata",   0, bus.s_rdata,        0);
    check("rst_fir_addr",  0, 32'(fir_addr_o),  0);
    check("rst_fir_coeff", 0, fir_coeff_o,      0);
    check("rst_wr_strobe", 0, 32'(wr_strobe_o), 0);
    check("rst_rd_strobe", 0, 32'(rd_strobe_o), 0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      model_txn(vec[i].is_wr, vec[i].addr, vec[i].ack_d, vec[i].hist, mr, md, ml, ms);
      apply("vec", i, vec[i].is_wr, vec[i].addr, vec[i].data, vec[i].hist, vec[i].ack_d,
            vec[i].e_resp, vec[i].e_rd, vec[i].e_lat, vec[i].e_strobe);
    end

    // Timeout, then a late ack: the following write must wait for its own ack
    model_txn(1'b1, 8'h0C, -1, 32'd0, mr, md, ml, ms);
    apply("late_to", 0, 1'b1, 8'h0C, 32'h1111, 32'd0, -1, mr, md, ml, ms);
    wr_ack_i = ~wr_ack_i;
    model_txn(1'b1, 8'h10, 6, 32'd0, mr, md, ml, ms);
    apply("late_next", 0, 1'b1, 8'h10, 32'h2222, 32'd0, 6, mr, md, ml, ms);

    // Write and read offered together: the write goes first
    wr_hs = -1; ar_hs = -1; bcyc = -1; rcyc = -1; rise = -1; ar_at_wr = 1;
    br = 2'b11; rr = 2'b11; rdv = 32'hFFFF_FFFF;
    model_txn(1'b0, 8'h44, -1, 32'd0, mr, md, ml, ms);
    @(posedge clk); #1;
    bus.s_awaddr = 8'h0C; bus.s_wdata = 32'h55AA; bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    bus.s_araddr = 8'h44; bus.s_arvalid = 1'b1;
    for (int i = 0; i < 200 && rcyc < 0; i++) begin
      @(negedge clk);
      hsw = bus.s_awready && bus.s_wready;
      hsr = bus.s_arready;
      if (hsw && wr_hs < 0) begin wr_hs = cyc; ar_at_wr = hsr; end
      if (hsr && ar_hs < 0) ar_hs = cyc;
      if (wr_strobe_o && rise < 0) rise = cyc;
      if (bus.s_bvalid && bcyc < 0) begin bcyc = cyc; br = bus.s_bresp; last_fall = cyc; end
      if (bus.s_rvalid && rcyc < 0) begin rcyc = cyc; rr = bus.s_rresp; rdv = bus.s_rdata; end
      @(posedge clk); #1;
      if (hsw) begin bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; end
      if (hsr) bus.s_arvalid = 1'b0;
      if (rise >= 0 && cyc == rise + 4) wr_ack_i = ~wr_ack_i;
    end
    check("both_write_first", 0, 32'(wr_hs >= 0 && ar_at_wr == 0), 1);
    check("both_bresp",       0, 32'(br), 32'(OKAY));
    check("both_wr_latency",  0, 32'(bcyc - rise), 7);
    check("both_ar_after_cooldown", 0, 32'(ar_hs - bcyc), 32'(SLC + 1));
    check("both_rresp",       0, 32'(rr), 32'(mr));
    check("both_rdata",       0, rdv, md);
    check("both_r_latency",   0, 32'(rcyc - ar_hs), 1);

    // Randomised traffic against the model
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 9));
      d = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, T));
      if (kind <= 3)      a = 8'($urandom_range(0, 8'h17));
      else if (kind == 4) a = 8'($urandom_range(8'h18, 8'hFF));
      else if (kind <= 7) a = 8'h40;
      else if (kind == 8) a = 8'h44;
      else begin
        a = 8'($urandom_range(0, 255));
        if (a == 8'h40 || a == 8'h44) a = 8'h80;
      end
      md = $urandom;
      model_txn(kind <= 4, a, d, md, mr, rdv, ml, ms);
      apply("rand", i, kind <= 4, a, $urandom, md, d, mr, rdv, ml, ms);
    end

    // Reset while a write strobe is up
    got = 0;
    @(posedge clk); #1;
    bus.s_awaddr = 8'h10; bus.s_wdata = 32'h3333; bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      hsw = bus.s_awready && bus.s_wready;
      if (wr_strobe_o) got = 1;
      @(posedge clk); #1;
      if (hsw) begin bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; end
    end
    check("rstmid_strobe_up", 0, 32'(got), 1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1; wr_ack_i = 1'b0; rd_ack_i = 1'b0;
    #1;
    check("rstmid_wr_strobe", 0, 32'(wr_strobe_o), 0);
    check("rstmid_bvalid",    0, 32'(bus.s_bvalid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_to = 16'd0;
    last_fall = -1000;
    model_txn(1'b0, 8'h44, -1, 32'd0, mr, md, ml, ms);
    apply("post_rst", 0, 1'b0, 8'h44, 32'd0, 32'd0, -1, mr, md, ml, ms);
    model_txn(1'b1, 8'h04, 5, 32'd0, mr, md, ml, ms);
    apply("post_rst", 1, 1'b1, 8'h04, 32'h4444, 32'd0, 5, mr, md, ml, ms);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
